// File: rtl/or1k_ticktimer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : or1k_ticktimer_pkg
// Description : Shared types, TTMR bit positions and SPR offsets for the
//               multi-channel OR1K tick timer.
// Revision    : 1.0 - initial release
// ============================================================================
package or1k_ticktimer_pkg;

    typedef enum logic [1:0] {
        TT_DISABLED = 2'b00,
        TT_RESTART  = 2'b01,
        TT_STOP     = 2'b10,
        TT_CONT     = 2'b11
    } tt_mode_e;

    localparam int MODE_HI = 31;
    localparam int MODE_LO = 30;
    localparam int IE_BIT  = 29;
    localparam int IP_BIT  = 28;

    localparam logic [10:0] TTPR_OFF  = 11'h020;
    localparam logic [10:0] TTISR_OFF = 11'h021;

    // Channel n owns TTMR at offset 2n and TTCR at 2n+1, so channel 0 keeps
    // the architectural locations.
    function automatic logic [10:0] chan_off(input int ch, input logic sel_ttcr);
        return 11'(2 * ch) | {10'd0, sel_ttcr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/or1k_ticktimer_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : or1k_ticktimer_mc_if
// Description : SPR bus bundle between the core and the tick timer unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface or1k_ticktimer_mc_if;

    logic        spr_access_i;
    logic        spr_we_i;
    logic [15:0] spr_addr_i;
    logic [31:0] spr_dat_i;
    logic        spr_bus_ack;
    logic [31:0] spr_dat_o;

    modport master (
        output spr_access_i,
        output spr_we_i,
        output spr_addr_i,
        output spr_dat_i,
        input  spr_bus_ack,
        input  spr_dat_o
    );

    modport slave (
        input  spr_access_i,
        input  spr_we_i,
        input  spr_addr_i,
        input  spr_dat_i,
        output spr_bus_ack,
        output spr_dat_o
    );

endinterface
`default_nettype wire

// File: rtl/or1k_ticktimer_chan.sv
`default_nettype none
// ============================================================================
// Module      : or1k_ticktimer_chan
// Description : One TTMR/TTCR channel: counter modes, period match and the
//               edge-triggered interrupt pending bit.
// Revision    : 1.0 - initial release
// ============================================================================
module or1k_ticktimer_chan
    import or1k_ticktimer_pkg::*;
#(
    parameter int MATCH_WIDTH = 28
) (
    input  wire         clk,
    input  wire         rst,
    input  wire         tick,
    input  wire         ttmr_we,
    input  wire         ttcr_we,
    input  wire  [31:0] wdata,
    input  wire         isr_clr,
    output logic [31:0] ttmr,
    output logic [31:0] ttcr,
    output logic        irq
);

    logic [31:0] r_ttmr;
    logic [31:0] r_ttcr;
    logic        r_match_q;

    tt_mode_e    w_mode;
    logic        w_match;
    logic        w_rise;
    logic        w_ip_set;
    logic [31:0] w_ttmr_nxt;
    logic [31:0] w_ttcr_nxt;

    assign w_mode   = tt_mode_e'(r_ttmr[MODE_HI:MODE_LO]);
    assign w_match  = (r_ttcr[MATCH_WIDTH-1:0] == r_ttmr[MATCH_WIDTH-1:0]);
    assign w_rise   = w_match & ~r_match_q;
    assign w_ip_set = r_ttmr[IE_BIT] & w_rise & (w_mode != TT_DISABLED);

    // A set event always beats any clear arriving in the same cycle.
    always_comb begin
        w_ttmr_nxt         = ttmr_we ? wdata : r_ttmr;
        w_ttmr_nxt[IP_BIT] = w_ip_set |
                             (ttmr_we ? wdata[IP_BIT] : (r_ttmr[IP_BIT] & ~isr_clr));
    end

    always_comb begin
        w_ttcr_nxt = r_ttcr;
        if (ttcr_we) begin
            w_ttcr_nxt = wdata;
        end else if (tick) begin
            case (w_mode)
                TT_RESTART: w_ttcr_nxt = w_match ? 32'd0 : r_ttcr + 32'd1;
                TT_STOP: begin
                    if (!w_match) begin
                        w_ttcr_nxt = r_ttcr + 32'd1;
                    end
                end
                TT_CONT:    w_ttcr_nxt = r_ttcr + 32'd1;
                default:    w_ttcr_nxt = r_ttcr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ttmr    <= '0;
            r_ttcr    <= '0;
            r_match_q <= 1'b0;
        end else begin
            r_ttmr    <= w_ttmr_nxt;
            r_ttcr    <= w_ttcr_nxt;
            r_match_q <= w_match;
        end
    end

    assign ttmr = r_ttmr;
    assign ttcr = r_ttcr;
    assign irq  = r_ttmr[IP_BIT];

endmodule
`default_nettype wire

// File: rtl/or1k_ticktimer_mc.sv
`default_nettype none
// ============================================================================
// Module      : or1k_ticktimer_mc
// Description : Multi-channel prescaled tick timer on the OR1K SPR bus with a
//               shared prescaler and write-1-to-clear interrupt status.
// Revision    : 1.0 - initial release
// ============================================================================
module or1k_ticktimer_mc
    import or1k_ticktimer_pkg::*;
#(
    parameter int NUM_TIMERS     = 4,
    parameter int MATCH_WIDTH    = 28,
    parameter int PRESCALE_WIDTH = 8
) (
    input  wire                       clk,
    input  wire                       rst,
    or1k_ticktimer_mc_if.slave        spr,
    output logic [32*NUM_TIMERS-1:0]  spr_ttmr_o,
    output logic [32*NUM_TIMERS-1:0]  spr_ttcr_o,
    output logic [NUM_TIMERS-1:0]     irq_o,
    output logic                      irq_any_o
);

    logic [10:0]               w_off;
    logic                      w_wr;
    logic                      w_ttpr_we;
    logic                      w_isr_we;
    logic                      w_tick;
    logic                      w_unused_addr;
    logic [31:0]               w_rdata;
    logic [PRESCALE_WIDTH-1:0] r_ttpr;
    logic [PRESCALE_WIDTH-1:0] r_pcnt;
    logic [31:0]               w_ttmr [NUM_TIMERS];
    logic [31:0]               w_ttcr [NUM_TIMERS];
    logic [NUM_TIMERS-1:0]     w_irq;

    assign w_off         = spr.spr_addr_i[10:0];
    assign w_unused_addr = ^spr.spr_addr_i[15:11];
    assign w_wr          = spr.spr_access_i & spr.spr_we_i;
    assign w_ttpr_we     = w_wr & (w_off == TTPR_OFF);
    assign w_isr_we      = w_wr & (w_off == TTISR_OFF);

    // Prescaler: TTPR of zero yields a tick every cycle, i.e. the legacy rate.
    assign w_tick = (r_pcnt == r_ttpr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ttpr <= '0;
            r_pcnt <= '0;
        end else if (w_ttpr_we) begin
            r_ttpr <= spr.spr_dat_i[PRESCALE_WIDTH-1:0];
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_chan
        logic w_ttmr_we;
        logic w_ttcr_we;

        assign w_ttmr_we = w_wr & (w_off == chan_off(n, 1'b0));
        assign w_ttcr_we = w_wr & (w_off == chan_off(n, 1'b1));

        or1k_ticktimer_chan #(
            .MATCH_WIDTH (MATCH_WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .tick    (w_tick),
            .ttmr_we (w_ttmr_we),
            .ttcr_we (w_ttcr_we),
            .wdata   (spr.spr_dat_i),
            .isr_clr (w_isr_we & spr.spr_dat_i[n]),
            .ttmr    (w_ttmr[n]),
            .ttcr    (w_ttcr[n]),
            .irq     (w_irq[n])
        );

        assign spr_ttmr_o[32*n +: 32] = w_ttmr[n];
        assign spr_ttcr_o[32*n +: 32] = w_ttcr[n];
    end

    // Unmapped offsets and channels beyond NUM_TIMERS fall through to zero.
    always_comb begin
        w_rdata = '0;
        if (spr.spr_access_i) begin
            if (w_off == TTPR_OFF) begin
                w_rdata[PRESCALE_WIDTH-1:0] = r_ttpr;
            end else if (w_off == TTISR_OFF) begin
                w_rdata[NUM_TIMERS-1:0] = w_irq;
            end else begin
                for (int i = 0; i < NUM_TIMERS; i++) begin
                    if (w_off == chan_off(i, 1'b0)) begin
                        w_rdata = w_ttmr[i];
                    end
                    if (w_off == chan_off(i, 1'b1)) begin
                        w_rdata = w_ttcr[i];
                    end
                end
            end
        end
    end

    assign spr.spr_dat_o   = w_rdata;
    assign spr.spr_bus_ack = spr.spr_access_i;
    assign irq_o           = w_irq;
    assign irq_any_o       = |w_irq;

endmodule
`default_nettype wire
